muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the RV32M operation set, parametrised in operand width XLEN.
- Sits beside the single-cycle ALU in the execute stage. The core stalls on busy and captures MDResult when done pulses.
- Uses a start/busy/done handshake. Multiply is radix-2 shift-add; divide is restoring, one quotient bit per cycle.

Parameters:
- XLEN, 32, operand and result width in bits (even, >= 8).
- CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- MDControl  input  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SrcA  input  XLEN  rs1 operand (multiplicand/dividend); sampled with start.
- SrcB  input  XLEN  rs2 operand (multiplier/divisor); sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; MDResult valid in that cycle.
- MDResult  output  XLEN  registered result; holds until the next done.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, MDResult=0, counter=0, internal accumulators=0. Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: on a clk edge with start=1, latch the operation and the operand magnitudes (|x| for signed operands per op), record result sign, counter=XLEN, go to CALC.
  - IDLE with a special case (see below): go directly to DONE instead.
  - CALC: each edge performs one iteration and decrements counter. On the edge where counter==1, write the sign-corrected result to MDResult and go to DONE.
  - DONE: done=1, busy=1; next edge goes to IDLE unconditionally.
- Latency: with sampling edge E, done is high in the cycle after edge E+XLEN (normal) or after edge E (special case).
- Throughput: a new start is accepted in the first IDLE cycle after DONE.
- start while busy=1 (CALC or DONE) is ignored. SrcA, SrcB and MDControl may change freely after the sampling edge.
- Multiply:
  - Forms the 2*XLEN-bit product of the magnitudes.
  - Negates the product if the result sign=1. Sign = A[msb]^B[msb] for MULH; A[msb] for MULHSU; 0 for MULHU and MUL.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - DIV/REM are signed; DIVU/REMU are unsigned. Quotient rounds toward zero.
  - The remainder takes the dividend's sign.
- Special cases, resolved in IDLE without iterating:
  - Divisor==0: DIV/DIVU -> all ones; REM/REMU -> SrcA.
  - Signed overflow (SrcA = 1<<(XLEN-1), SrcB = all ones) for DIV: result = SrcA. For REM: result = 0.
- MUL by zero is not special-cased and takes the full latency.
- MDResult changes only on the edge that enters DONE; at all other times it holds its value.

Test Plan:
- Reset mid-CALC: start MUL, assert reset at cycle 10 -> busy=0, done=0 and MDResult=0 immediately. After release, no stray done appears and the next start works normally.
- MUL/MULHU, XLEN=32: SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> MUL=0x00000001, MULHU=0xFFFFFFFE. done rises exactly 32 cycles after the start-sampling edge and lasts 1 cycle.
- MULH/MULHSU: SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> MULH=0xFFFFFFFF, MUL=0xFFFFFFFA. MULHSU with SrcB=0x80000000 -> 0xFFFFFFFF.
- DIV/REM signed: SrcA=0xFFFFFFF9 (-7), SrcB=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF. DIVU of the same operands -> 0x7FFFFFFC; REMU -> 1.
- Special cases: DIV with SrcB=0, SrcA=0x1234 -> 0xFFFFFFFF; REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Each gives done one cycle after sampling.
- Handshake: hold start=1 continuously for 3 back-to-back ops -> each op is accepted only in IDLE. Operands changed during CALC do not affect results. MDResult is stable between done pulses.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Multiply: radix-2 shift-add on operand magnitudes, sign fixed at the end.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle.
//   Divide-by-zero and signed overflow resolve in IDLE without iterating.
// Handshake: start is sampled only while busy=0. busy is high in CALC and DONE.
//   done pulses for one cycle in DONE. MDResult is registered and holds its
//   value until the next done.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               operation request
//   MDControl[2:0]      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   SrcA, SrcB          rs1 / rs2 operands, sampled together with start
//   busy, done          handshake status
//   MDResult            result register
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      MDControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MDResult
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sign_q, sign_d;   // negate the final result
  logic [XLEN-1:0]   mag_q, mag_d;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // multiplier bits / dividend-quotient
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand decode for the request presented in IDLE.
  logic            a_signed, b_signed, a_neg, b_neg, in_sign;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign a_signed = (MDControl == OP_MULH) || (MDControl == OP_MULHSU) ||
                    (MDControl == OP_DIV)  || (MDControl == OP_REM);
  assign b_signed = (MDControl == OP_MULH) || (MDControl == OP_DIV) ||
                    (MDControl == OP_REM);
  assign a_neg    = a_signed & SrcA[XLEN-1];
  assign b_neg    = b_signed & SrcB[XLEN-1];
  assign a_mag    = a_neg ? -SrcA : SrcA;
  assign b_mag    = b_neg ? -SrcB : SrcB;

  // Quotient sign is a^b; remainder follows the dividend; MUL low half
  // is sign-agnostic so it is treated as unsigned.
  always_comb begin
    in_sign = 1'b0;
    case (MDControl)
      OP_MULH, OP_DIV: in_sign = a_neg ^ b_neg;
      OP_MULHSU, OP_REM: in_sign = a_neg;
      default: in_sign = 1'b0;
    endcase
  end

  assign div_zero = MDControl[2] && (SrcB == '0);
  assign div_ovf  = ((MDControl == OP_DIV) || (MDControl == OP_REM)) &&
                    (SrcA == INT_MIN) && (SrcB == '1);
  // MDControl[1] distinguishes REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (MDControl[1] ? SrcA : '1)
                                : (MDControl[1] ? '0 : SrcA);

  // One iteration of the selected algorithm.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              q_bit;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_val, div_fix, final_res;

  assign mul_sum   = {1'b0, hi_q} + ({(XLEN+1){lo_q[0]}} & {1'b0, mag_q});
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag_q};
  assign q_bit     = ~div_diff[XLEN];

  always_comb begin
    if (op_q[2]) begin
      // Shifted remainder is below 2*divisor, so it always fits in XLEN bits
      // after a successful or skipped subtraction.
      hi_n = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], q_bit};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod     = {hi_n, lo_n};
  assign prod_fix = sign_q ? -prod : prod;
  assign div_val  = op_q[1] ? hi_n : lo_n;
  assign div_fix  = sign_q ? -div_val : div_val;

  always_comb begin
    case (op_q)
      OP_MUL: final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      default: final_res = div_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = MDControl;
          sign_d = in_sign;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else begin
            cnt_d = CNTW'(XLEN);
            hi_d  = '0;
            if (MDControl[2]) begin
              mag_d = b_mag;
              lo_d  = a_mag;
            end else begin
              mag_d = a_mag;
              lo_d  = b_mag;
            end
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          res_d   = final_res;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign MDResult = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      MDControl;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] MDResult;

  int n_chk = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .MDControl(MDControl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .MDResult(MDResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model written directly from the RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (op)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; model = up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); up = 64'(sp); model = up[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); up = 64'(sp); model = up[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; model = up[63:32]; end
      3'd4: model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: model = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && (b == 0)) return 0;
    if (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return 0;
    return XLEN;
  endfunction

  // Issue one operation, scramble inputs while it runs, and check result,
  // latency (edges after the sampling edge), done width and result stability.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] prev;
    int lat;
    bit seen, moved;
    @(negedge clk);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk({name, "_idle_before"}, {31'b0, busy}, 32'd0);
    prev = MDResult;
    MDControl = op; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; seen = 0; moved = 0;
    while (!seen && lat <= XLEN + 4) begin
      if (done) seen = 1;
      else begin
        if (MDResult !== prev) moved = 1;
        MDControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom; start = 1'($urandom);
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    chk({name, "_latency"}, seen ? 32'(lat) : 32'hDEAD_BEEF, 32'(exp_lat));
    chk({name, "_result"}, MDResult, exp);
    chk({name, "_stable_while_busy"}, {31'b0, moved}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({name, "_result_held"}, MDResult, exp);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{"mul_ff_ff",     3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32};
    vecs[1]  = '{"mulhu_ff_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
    vecs[2]  = '{"mulh_m2_3",     3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32};
    vecs[3]  = '{"mul_m2_3",      3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32};
    vecs[4]  = '{"mulhsu_m2_big", 3'd2, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, 32};
    vecs[5]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32};
    vecs[6]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32};
    vecs[7]  = '{"divu_m7_2",     3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32};
    vecs[8]  = '{"remu_m7_2",     3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32};
    vecs[9]  = '{"div_by_zero",   3'd4, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 0};
    vecs[10] = '{"remu_by_zero",  3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 0};
    vecs[11] = '{"div_overflow",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
    vecs[12] = '{"rem_overflow",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
    vecs[13] = '{"mul_by_zero",   3'd0, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32};

    reset = 1'b1; start = 1'b0; MDControl = '0; SrcA = '0; SrcB = '0;
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", MDResult, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table.
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Reset in the middle of a multiply aborts it with no done.
    begin
      int stray;
      @(negedge clk);
      MDControl = 3'd0; SrcA = 32'h1357_9BDF; SrcB = 32'h2468_ACE0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      chk("midcalc_busy_before_reset", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midcalc_reset_busy", {31'b0, busy}, 32'd0);
      chk("midcalc_reset_done", {31'b0, done}, 32'd0);
      chk("midcalc_reset_result", MDResult, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done || busy) stray++;
      end
      chk("midcalc_no_stray_activity", 32'(stray), 32'd0);
      run_op("after_reset_mulhu", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32);
    end

    // start held high across three back-to-back operations.
    begin
      logic [2:0]  b_op[3];
      logic [31:0] b_a[3], b_b[3], b_exp[3];
      int idx, exp_t;
      b_op[0] = 3'd0; b_a[0] = 32'd7;         b_b[0] = 32'd9; b_exp[0] = 32'd63;
      b_op[1] = 3'd5; b_a[1] = 32'd100;       b_b[1] = 32'd7; b_exp[1] = 32'd14;
      b_op[2] = 3'd6; b_a[2] = 32'hFFFF_FFF9; b_b[2] = 32'd2; b_exp[2] = 32'hFFFF_FFFF;
      @(negedge clk);
      MDControl = b_op[0]; SrcA = b_a[0]; SrcB = b_b[0]; start = 1'b1;
      idx = 0;
      for (int t = 0; t < 200 && idx < 3; t++) begin
        @(posedge clk); #1;
        if (done) begin
          exp_t = idx * (XLEN + 2) + XLEN;
          chk($sformatf("b2b_%0d_time", idx), 32'(t), 32'(exp_t));
          chk($sformatf("b2b_%0d_result", idx), MDResult, b_exp[idx]);
          idx++;
          if (idx < 3) begin
            MDControl = b_op[idx]; SrcA = b_a[idx]; SrcB = b_b[idx];
          end else start = 1'b0;
        end
      end
      start = 1'b0;
      chk("b2b_count", 32'(idx), 32'd3);
    end

    // Randomised operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
        3: begin a = -32'($urandom_range(0, 255)); b = -32'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op($sformatf("rand_%0d_op%0d", n, op), op, a, b, model(op, a, b), model_lat(op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
